// File: rtl/mc_mem_responder_if.sv
// mc_mem_responder_if - request/response bundle between a multicycle core
// and its unified instruction/data memory responder.
//   req, we, adr, wdata, be : request, driven by the core (master)
//   rdata, ready, err, busy : response/status, driven by the memory (slave)
interface mc_mem_responder_if;
  logic        req;
  logic        we;
  logic [31:0] adr;
  logic [31:0] wdata;
  logic [3:0]  be;
  logic [31:0] rdata;
  logic        ready;
  logic        err;
  logic        busy;

  modport master (output req, we, adr, wdata, be, input rdata, ready, err, busy);
  modport slave  (input req, we, adr, wdata, be, output rdata, ready, err, busy);
endinterface

// File: rtl/mc_mem_responder.sv
// mc_mem_responder - word-organised memory responder for a multicycle core.
// A request is accepted in IDLE. The response is a one-cycle ready pulse in
// RESP, carrying err for misaligned or out-of-range accesses and rdata for
// reads. Writes commit their enabled bytes on the edge that enters RESP.
//
// Optional feature: define MC_MEM_WAIT_EN to insert WAIT_CYCLES wait states
// (a WAIT state plus down-counter) between acceptance and RESP.
//
// Ports:
//   clk   : clock, rising edge
//   reset : asynchronous reset, active low
//   bus   : mc_mem_responder_if.slave (req/we/adr/wdata/be in,
//           rdata/ready/err/busy out)
// Parameters:
//   DEPTH_WORDS : number of 32-bit words (power of two)
//   WAIT_CYCLES : wait states with MC_MEM_WAIT_EN (1..15)
module mc_mem_responder #(
  parameter int DEPTH_WORDS = 256,
  parameter int WAIT_CYCLES = 2
) (
  input  logic               clk,
  input  logic               reset,
  mc_mem_responder_if.slave  bus
);
  localparam int          AW    = $clog2(DEPTH_WORDS);
  localparam logic [31:0] LIMIT = 32'(4 * DEPTH_WORDS);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
`ifdef MC_MEM_WAIT_EN
    WAIT = 2'd1,
`endif
    RESP = 2'd2
  } state_t;

  state_t state, state_nxt;

  logic [31:0] mem [DEPTH_WORDS];

  // request attributes held for the rest of the transaction
  logic          we_q;
  logic          fault_q;
  logic [AW-1:0] idx_q;

  logic          accept;
  logic          in_fault;
  logic [AW-1:0] in_idx;

  // write port, selected from live inputs or captured request
  logic          commit;
  logic [AW-1:0] cm_idx;
  logic [31:0]   cm_data;
  logic [3:0]    cm_be;

  assign accept   = (state == IDLE) && bus.req;
  assign in_fault = (bus.adr[1:0] != 2'b00) || (bus.adr >= LIMIT);
  assign in_idx   = bus.adr[AW+1:2];

`ifdef MC_MEM_WAIT_EN
  logic [3:0]  cnt;
  logic [31:0] wdata_q;
  logic [3:0]  be_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt <= 4'd0;
    end else if (accept) begin
      cnt <= 4'(WAIT_CYCLES - 1);
    end else if (state == WAIT && cnt != 4'd0) begin
      cnt <= cnt - 4'd1;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wdata_q <= 32'd0;
      be_q    <= 4'd0;
    end else if (accept) begin
      wdata_q <= bus.wdata;
      be_q    <= bus.be;
    end
  end

  // commit on the WAIT->RESP edge; a reset in WAIT drops the write
  assign commit  = reset && (state == WAIT) && (cnt == 4'd0) && we_q && !fault_q;
  assign cm_idx  = idx_q;
  assign cm_data = wdata_q;
  assign cm_be   = be_q;
`else
  localparam int unused_wait_cycles = WAIT_CYCLES;

  // acceptance edge is the edge entering RESP, so commit straight from the bus
  assign commit  = reset && accept && bus.we && !in_fault;
  assign cm_idx  = in_idx;
  assign cm_data = bus.wdata;
  assign cm_be   = bus.be;
`endif

  // storage is deliberately not reset
  always_ff @(posedge clk) begin
    if (commit) begin
      for (int i = 0; i < 4; i++) begin
        if (cm_be[i]) mem[cm_idx][8*i +: 8] <= cm_data[8*i +: 8];
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      we_q    <= 1'b0;
      fault_q <= 1'b0;
      idx_q   <= '0;
    end else if (accept) begin
      we_q    <= bus.we;
      fault_q <= in_fault;
      idx_q   <= in_idx;
    end
  end

  // state register
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= IDLE;
    else        state <= state_nxt;
  end

  // next state
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: begin
        if (bus.req) begin
`ifdef MC_MEM_WAIT_EN
          state_nxt = WAIT;
`else
          state_nxt = RESP;
`endif
        end
      end
`ifdef MC_MEM_WAIT_EN
      WAIT: if (cnt == 4'd0) state_nxt = RESP;
`endif
      RESP:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // outputs
  always_comb begin
    bus.ready = 1'b0;
    bus.err   = 1'b0;
    bus.rdata = 32'd0;
    bus.busy  = (state != IDLE);
    if (state == RESP) begin
      bus.ready = 1'b1;
      bus.err   = fault_q;
      if (!we_q && !fault_q) bus.rdata = mem[idx_q];
    end
  end
endmodule

// File: tb/tb_mc_mem_responder.sv
module tb_mc_mem_responder;
  localparam int DEPTH = 256;
  localparam int WC    = 2;
`ifdef MC_MEM_WAIT_EN
  localparam int LAT = 1 + WC;
`else
  localparam int LAT = 1;
`endif

  logic clk = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;

  mc_mem_responder_if bus();

  mc_mem_responder #(.DEPTH_WORDS(DEPTH), .WAIT_CYCLES(WC)) dut (
    .clk(clk), .reset(reset), .bus(bus)
  );

  int pass_cnt = 0;
  int total_cnt = 0;
  logic [31:0] mdl [DEPTH];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total_cnt++;
    assert (obs === exp) pass_cnt++;
    else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
  endtask

  // one transaction from idle; lat = edges from acceptance to the ready sample
  task automatic txn(input logic w, input logic [31:0] a, input logic [31:0] d,
                     input logic [3:0] b, output logic [31:0] rd, output logic e,
                     output int lat);
    rd = 32'hx; e = 1'bx; lat = 0;
    @(negedge clk);
    bus.req = 1'b1; bus.we = w; bus.adr = a; bus.wdata = d; bus.be = b;
    @(posedge clk);
    #1 bus.req = 1'b0;
    for (int i = 1; i <= 20; i++) begin
      @(negedge clk);
      if (bus.ready === 1'b1) begin
        lat = i; rd = bus.rdata; e = bus.err;
        break;
      end
    end
    @(negedge clk);
    chk("post_busy", 32'(bus.busy), 32'd0);
    chk("post_ready", 32'(bus.ready), 32'd0);
  endtask

  task automatic do_check(input string tag, input logic w, input logic [31:0] a,
                          input logic [31:0] d, input logic [3:0] b);
    logic        f;
    logic [31:0] exp_rd, rd;
    logic        e;
    int          lat;
    f = (a % 4 != 0) || (a >= 4 * DEPTH);
    exp_rd = (w || f) ? 32'd0 : mdl[a / 4];
    txn(w, a, d, b, rd, e, lat);
    chk({tag, "_lat"}, 32'(lat), 32'(LAT));
    chk({tag, "_err"}, 32'(e), 32'(f));
    chk({tag, "_rdata"}, rd, exp_rd);
    if (w && !f) begin
      for (int k = 0; k < 4; k++)
        if (b[k]) mdl[a / 4][8*k +: 8] = d[8*k +: 8];
    end
  endtask

  initial begin
    logic [31:0] a, d;
    logic [3:0]  b;
    logic        w;
    int last, pulses, exp_pulses;
    logic seen_ready;

    bus.req = 1'b0; bus.we = 1'b0; bus.adr = 32'd0; bus.wdata = 32'd0; bus.be = 4'd0;

    // reset state
    @(posedge clk);
    #1;
    chk("rst_ready", 32'(bus.ready), 32'd0);
    chk("rst_err", 32'(bus.err), 32'd0);
    chk("rst_busy", 32'(bus.busy), 32'd0);
    chk("rst_rdata", bus.rdata, 32'd0);
    @(negedge clk) reset = 1'b1;

    // fill all storage so the model is fully known
    for (int i = 0; i < DEPTH; i++) do_check("fill", 1'b1, 32'(i * 4), $urandom, 4'hF);

    // directed cases
    do_check("wr10", 1'b1, 32'h10, 32'hDEADBEEF, 4'hF);
    do_check("rd10", 1'b0, 32'h10, 32'h0, 4'h0);
    do_check("wrb0", 1'b1, 32'h10, 32'h000000AA, 4'b0001);
    do_check("rdb0", 1'b0, 32'h10, 32'h0, 4'h0);
    chk("byte_merge", mdl[4], 32'hDEADBEAA);
    do_check("mis12", 1'b0, 32'h12, 32'h0, 4'h0);
    do_check("oor400", 1'b0, 32'h400, 32'h0, 4'h0);
    do_check("wrmis", 1'b1, 32'h13, 32'hFFFFFFFF, 4'hF);
    do_check("wroor", 1'b1, 32'h400, 32'hFFFFFFFF, 4'hF);
    do_check("rd10b", 1'b0, 32'h10, 32'h0, 4'h0);
    do_check("be0", 1'b1, 32'h10, 32'h12345678, 4'b0000);
    do_check("rd10c", 1'b0, 32'h10, 32'h0, 4'h0);
    do_check("last", 1'b1, 32'h3FC, 32'hCAFEF00D, 4'hF);
    do_check("rdlast", 1'b0, 32'h3FC, 32'h0, 4'h0);

    // random traffic against the model
    for (int i = 0; i < 200; i++) begin
      w = 1'($urandom_range(0, 1));
      d = $urandom;
      b = 4'($urandom_range(0, 15));
      case ($urandom_range(0, 3))
        0, 1: a = 32'($urandom_range(0, DEPTH - 1)) * 4;
        2:    a = 32'($urandom_range(0, DEPTH - 1)) * 4 + 32'($urandom_range(1, 3));
        default: begin
          a = $urandom;
          if (a < 4 * DEPTH) a = a + 4 * DEPTH;
        end
      endcase
      do_check("rnd", w, a, d, b);
    end

    // req held high: ready pulses spaced by one idle cycle plus latency
    @(negedge clk);
    bus.req = 1'b1; bus.we = 1'b0; bus.adr = 32'h10;
    last = -1; pulses = 0; seen_ready = 1'b0;
    for (int i = 1; i <= 24; i++) begin
      @(negedge clk);
      if (seen_ready) chk("hold_busy_after_ready", 32'(bus.busy), 32'd0);
      seen_ready = bus.ready;
      if (bus.ready === 1'b1) begin
        pulses++;
        chk("hold_rdata", bus.rdata, mdl[4]);
        if (last >= 0) chk("hold_gap", 32'(i - last), 32'(LAT + 1));
        last = i;
      end
    end
    bus.req = 1'b0;
    exp_pulses = (24 - LAT) / (LAT + 1) + 1;
    chk("hold_pulses", 32'(pulses), 32'(exp_pulses));
    for (int i = 0; i < 2 * LAT + 4; i++) @(negedge clk);

    // reset mid-transaction: outputs clear without a clock edge, no ready
    @(negedge clk);
`ifdef MC_MEM_WAIT_EN
    bus.req = 1'b1; bus.we = 1'b1; bus.adr = 32'h20; bus.wdata = 32'h12345678; bus.be = 4'hF;
`else
    bus.req = 1'b1; bus.we = 1'b0; bus.adr = 32'h10;
`endif
    @(posedge clk);
    #2 bus.req = 1'b0;
    chk("pre_rst_busy", 32'(bus.busy), 32'd1);
    reset = 1'b0;
    #1;
    chk("arst_busy", 32'(bus.busy), 32'd0);
    chk("arst_ready", 32'(bus.ready), 32'd0);
    chk("arst_err", 32'(bus.err), 32'd0);
    chk("arst_rdata", bus.rdata, 32'd0);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("arst_noready", 32'(bus.ready), 32'd0);
    end
    reset = 1'b1;
    do_check("rd20", 1'b0, 32'h20, 32'h0, 4'h0);
    do_check("rd10_kept", 1'b0, 32'h10, 32'h0, 4'h0);

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end
endmodule

// File: doc/mc_mem_responder.md
MC_MEM_RESPONDER -- requirements
Module: mc_mem_responder

Interface
REQ-001 SHALL have parameter DEPTH_WORDS, default 256, meaning the number of 32-bit words of unified instruction/data storage (power of two).
REQ-002 SHALL have parameter WAIT_CYCLES, default 2, meaning the wait states inserted before a response when MC_MEM_WAIT_EN is defined (range 1..15).
REQ-003 SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-004 SHALL have port reset, input, 1 bit: reset, asynchronous and active-low (0 = reset asserted).
REQ-005 SHALL have port req, input, 1 bit: access request from the multicycle core.
REQ-006 SHALL have port we, input, 1 bit: 1 = write, 0 = read; sampled with req.
REQ-007 SHALL have port adr, input, 32 bits: byte address; sampled with req.
REQ-008 SHALL have port wdata, input, 32 bits: write data; sampled with req.
REQ-009 SHALL have port be, input, 4 bits: byte enables for writes, be[i] enables wdata[8i+7:8i]; sampled with req.
REQ-010 SHALL have port rdata, output, 32 bits: read data, valid while ready=1.
REQ-011 SHALL have port ready, output, 1 bit: one-cycle response pulse.
REQ-012 SHALL have port err, output, 1 bit: access fault, valid while ready=1.
REQ-013 SHALL have port busy, output, 1 bit: 1 whenever the FSM is not in IDLE.

Function
REQ-014 SHALL implement FSM states IDLE, WAIT, RESP.
REQ-015 In IDLE, req=1 SHALL capture we/adr/wdata/be and transition to WAIT if MC_MEM_WAIT_EN is defined, else to RESP.
REQ-016 In WAIT, a down-counter loaded with WAIT_CYCLES-1 at acceptance SHALL decrement each cycle; at 0 the FSM SHALL move to RESP.
REQ-017 In RESP, ready=1 for exactly one cycle, then the FSM SHALL return to IDLE.
REQ-018 Latency, acceptance edge to ready: 1 cycle without the macro; 1+WAIT_CYCLES cycles with it.
REQ-019 req while busy=1 SHALL be ignored; a new request can be accepted no earlier than the cycle after ready.
REQ-020 Word index SHALL be adr[log2(DEPTH_WORDS)+1:2].
REQ-021 Fault when adr[1:0]!=0 or adr >= 4*DEPTH_WORDS; a fault SHALL set err=1 with ready, rdata=0, and no storage update.
REQ-022 A write SHALL update only the enabled bytes on the clock edge entering RESP; rdata=0 for writes.
REQ-023 A read SHALL present the stored word on rdata in RESP, reflecting all writes completed by earlier transactions.
REQ-024 be=4'b0000 on a write SHALL complete normally (ready=1, err=0) with no storage change.
REQ-025 Outside RESP, rdata=0 and err=0.

Reset
REQ-026 reset=0 SHALL immediately force IDLE, ready=0, err=0, busy=0, rdata=0, counter=0, independent of clk.
REQ-027 Reset during WAIT or RESP SHALL abort the transaction with no response; a write not yet committed SHALL NOT modify storage.
REQ-028 Storage contents SHALL NOT be cleared by reset.

Configuration
REQ-029 Macro MC_MEM_WAIT_EN: when defined, the WAIT state and counter SHALL be compiled in (per REQ-016); when undefined, WAIT and the counter SHALL be absent and WAIT_CYCLES ignored.

Verification
REQ-030 Write adr=0x10, wdata=0xDEADBEEF, be=4'hF, then read adr=0x10 -> ready pulse with err=0 and rdata=0xDEADBEEF; latency 1 cycle (macro off) or 3 cycles (macro on, WAIT_CYCLES=2).
REQ-031 Over word 0xDEADBEEF, write wdata=0x000000AA with be=4'b0001 and read back -> rdata=0xDEADBEAA.
REQ-032 Read adr=0x12 and read adr=0x400 (DEPTH_WORDS=256) -> ready=1, err=1, rdata=0; a subsequent read of 0x10 is unchanged.
REQ-033 Hold req=1 continuously for 10 cycles -> each ready pulse is followed by at least one busy=0 cycle; no request is accepted while busy=1.
REQ-034 Assert reset=0 mid-WAIT during a write of 0x12345678 to 0x20 -> outputs clear asynchronously, no ready, and a later read of 0x20 returns the prior contents.
